// File: rtl/run_ctrl.sv
// Run sequencer: turns a host start pulse into a timed core reset and a gated run
// window, counts RUN cycles and reports halt (done) or watchdog expiry (timed_out).
module run_ctrl #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 abort,
  input  logic                 core_done,
  output logic                 core_rst,
  output logic                 core_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  localparam int unsigned         RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]       RST_LOAD = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_VAL   = CNT_WIDTH'(TIMEOUT);
  localparam bit                   TO_EN    = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE,
    RSTC,
    RUN,
    DONE,
    FAULT
  } state_t;

  state_t               state, state_nx;
  logic                 req_q;
  logic                 start;
  logic [RCW-1:0]       rst_cnt, rst_cnt_nx;
  logic [CNT_WIDTH-1:0] cnt_nx, cnt_inc;
  logic [4:0]           flags_nx;

  assign start = req & ~req_q;

  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    cnt_nx     = cycle_cnt;
    cnt_inc    = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx   = RSTC;
          rst_cnt_nx = RST_LOAD;
          cnt_nx     = '0;
        end
      end
      RSTC: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (rst_cnt == '0) begin
          state_nx = RUN;
        end else begin
          rst_cnt_nx = rst_cnt - RCW'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_inc;
          // core_done wins over a watchdog expiry landing on the same cycle
          if (core_done) begin
            state_nx = DONE;
          end else if (TO_EN && (cnt_inc == TO_VAL)) begin
            state_nx = FAULT;
          end
        end
      end
      DONE, FAULT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (start) begin
          state_nx   = RSTC;
          rst_cnt_nx = RST_LOAD;
          cnt_nx     = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output flops are loaded from the decode of the next state, so each output
  // is a clean register that still tracks the state in the same cycle.
  always_comb begin
    flags_nx = 5'b10000;
    unique case (state_nx)
      IDLE:    flags_nx = 5'b10000;
      RSTC:    flags_nx = 5'b10100;
      RUN:     flags_nx = 5'b01100;
      DONE:    flags_nx = 5'b00010;
      FAULT:   flags_nx = 5'b00011;
      default: flags_nx = 5'b10000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nx;
      req_q     <= req;
      rst_cnt   <= rst_cnt_nx;
      cycle_cnt <= cnt_nx;
      {core_rst, core_en, busy, done, timed_out} <= flags_nx;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: directed stimulus queues expected outputs per cycle,
// independent monitors pop and compare them.
module tb_run_ctrl;

  localparam logic [4:0] F_IDLE  = 5'b10000;
  localparam logic [4:0] F_RSTC  = 5'b10100;
  localparam logic [4:0] F_RUN   = 5'b01100;
  localparam logic [4:0] F_DONE  = 5'b00010;
  localparam logic [4:0] F_FAULT = 5'b00011;

  typedef struct {
    string       name;
    int unsigned at;
    bit          dut_b;
    logic [4:0]  fl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk, reset;
  logic        req, abort, core_done;
  logic        req_b, core_done_b;
  logic        a_rst, a_en, a_busy, a_done, a_to;
  logic [15:0] a_cnt;
  logic        b_rst, b_en, b_busy, b_done, b_to;
  logic [3:0]  b_cnt;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned c0;
  exp_t        sq[$];
  exp_t        aq[$];
  event        async_ev;

  run_ctrl #(.RST_CYCLES(2), .CNT_WIDTH(16), .TIMEOUT(20)) u_a (
    .clk(clk), .reset(reset), .req(req), .abort(abort), .core_done(core_done),
    .core_rst(a_rst), .core_en(a_en), .busy(a_busy), .done(a_done),
    .timed_out(a_to), .cycle_cnt(a_cnt)
  );

  run_ctrl #(.RST_CYCLES(1), .CNT_WIDTH(4), .TIMEOUT(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .abort(1'b0), .core_done(core_done_b),
    .core_rst(b_rst), .core_en(b_en), .busy(b_busy), .done(b_done),
    .timed_out(b_to), .cycle_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input string nm, input int unsigned at, input bit b,
                    input logic [4:0] fl, input logic [15:0] cnt);
    exp_t e;
    e.name = nm; e.at = at; e.dut_b = b; e.fl = fl; e.cnt = cnt;
    sq.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [20:0] act;
    act = e.dut_b ? {b_rst, b_en, b_busy, b_done, b_to, 12'b0, b_cnt}
                  : {a_rst, a_en, a_busy, a_done, a_to, a_cnt};
    n_cmp++;
    if (act !== {e.fl, e.cnt}) begin
      n_bad++;
      $display("FAIL %s: got rst/en/busy/done/to=%b cnt=%0d, expected %b cnt=%0d",
               e.name, act[20:16], act[15:0], e.fl, e.cnt);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // cycle-aligned monitor: entries are due after edge 'at', sampled on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].at <= cyc) begin
        e = sq.pop_front();
        if (e.at < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: stale expectation for edge %0d, now %0d", e.name, e.at, cyc);
        end else begin
          check(e);
        end
      end
    end
  end

  // asynchronous monitor for checks that must not wait for a clock edge
  initial begin
    forever begin
      @(async_ev);
      while (aq.size() > 0) check(aq.pop_front());
    end
  end

  initial begin
    exp_t ea;
    reset = 1'b0; req = 1'b0; abort = 1'b0; core_done = 1'b0;
    req_b = 1'b0; core_done_b = 1'b0;
    step(2);
    ex("reset_a", cyc, 0, F_IDLE, 0);
    ex("reset_b", cyc, 1, F_IDLE, 0);
    reset = 1'b1;
    step(2);

    // basic run: req sampled at edge 5, halt in 10th RUN cycle
    c0 = cyc; req = 1'b1;
    ex("rstc1",     c0 + 1,  0, F_RSTC, 0);
    ex("rstc2",     c0 + 2,  0, F_RSTC, 0);
    ex("run0",      c0 + 3,  0, F_RUN,  0);
    ex("run9",      c0 + 12, 0, F_RUN,  9);
    ex("done",      c0 + 13, 0, F_DONE, 10);
    ex("done_hold", c0 + 15, 0, F_DONE, 10);
    step(); req = 1'b0;
    step(11); core_done = 1'b1;
    step(); core_done = 1'b0;
    step(2);

    // restart from DONE, ignored pulses in RSTC/RUN, watchdog expiry
    c0 = cyc; req = 1'b1;
    ex("restart",    c0 + 1,  0, F_RSTC,  0);
    ex("rstc_pulse", c0 + 3,  0, F_RUN,   0);
    ex("run6",       c0 + 9,  0, F_RUN,   6);
    ex("run19",      c0 + 22, 0, F_RUN,   19);
    ex("fault",      c0 + 23, 0, F_FAULT, 20);
    ex("fault_hold", c0 + 26, 0, F_FAULT, 20);
    step(); req = 1'b0;
    step(); req = 1'b1;
    step(); req = 1'b0;
    step(5); req = 1'b1;
    step(); req = 1'b0;
    step(17);

    // abort beats a simultaneous start in FAULT
    c0 = cyc; req = 1'b1; abort = 1'b1;
    ex("abort_fault", c0 + 1, 0, F_IDLE, 20);
    ex("idle_hold",   c0 + 3, 0, F_IDLE, 20);
    step(); abort = 1'b0;
    step(); req = 1'b0;
    step();

    // core_done together with the timeout cycle
    c0 = cyc; req = 1'b1;
    ex("sim_run19", c0 + 22, 0, F_RUN,  19);
    ex("sim_done",  c0 + 23, 0, F_DONE, 20);
    step(); req = 1'b0;
    step(21); core_done = 1'b1;
    step(); core_done = 1'b0;

    // restart from DONE, core_done in RSTC ignored, abort on the timeout cycle
    c0 = cyc; req = 1'b1;
    ex("restart2",      c0 + 1,  0, F_RSTC, 0);
    ex("rstc_done_ign", c0 + 3,  0, F_RUN,  0);
    ex("sim_abort",     c0 + 23, 0, F_IDLE, 19);
    step(); req = 1'b0; core_done = 1'b1;
    step(2); core_done = 1'b0;
    step(19); core_done = 1'b1; abort = 1'b1;
    step(); core_done = 1'b0; abort = 1'b0;
    c0 = cyc;
    ex("idle_done_ign", c0 + 2, 0, F_IDLE, 19);
    core_done = 1'b1;
    step(2); core_done = 1'b0;

    // req held high across a whole run: one run only
    c0 = cyc; req = 1'b1;
    ex("held_run",   c0 + 10, 0, F_RUN,   7);
    ex("held_fault", c0 + 30, 0, F_FAULT, 20);
    ex("held_end",   c0 + 50, 0, F_FAULT, 20);
    step(50); req = 1'b0;
    step();

    // asynchronous reset between edges while cycle_cnt is 7
    c0 = cyc; req = 1'b1;
    ex("pre_reset", c0 + 10, 0, F_RUN, 7);
    step(); req = 1'b0;
    step(9);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    ea.name = "async_reset"; ea.at = cyc; ea.dut_b = 0; ea.fl = F_IDLE; ea.cnt = 0;
    aq.push_back(ea);
    -> async_ev;
    #1;
    @(posedge clk);
    #1;
    ex("after_reset", cyc, 0, F_IDLE, 0);
    reset = 1'b1;
    step();

    // TIMEOUT=0, 4-bit counter, RST_CYCLES=1: saturate at 15 and stay in RUN
    c0 = cyc; req_b = 1'b1;
    ex("b_rstc",     c0 + 1,  1, F_RSTC, 0);
    ex("b_run0",     c0 + 2,  1, F_RUN,  0);
    ex("b_run14",    c0 + 16, 1, F_RUN,  14);
    ex("b_sat",      c0 + 17, 1, F_RUN,  15);
    ex("b_sat_hold", c0 + 30, 1, F_RUN,  15);
    step(); req_b = 1'b0;
    step(29);
    step(2);

    if (sq.size() != 0 || aq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expectations never compared, required 0", sq.size() + aq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run sequencer for the single-cycle core.
- Turns a host req pulse into a timed core reset, then a run window.
- Gates core execution, counts executed cycles, and reports completion (core halt) or a watchdog timeout back to the host via done/timed_out.
- Sits between the test harness and the core's reset/clock-enable inputs, with the core's done flag fed back as core_done.

Parameters:
RST_CYCLES, 2, cycles core_rst is held high after a start; legal range ≥1
CNT_WIDTH, 16, width of cycle_cnt
TIMEOUT, 4096, watchdog limit in RUN cycles; 0 disables the watchdog; must be < 2^CNT_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  host start request; rising edge starts a run
abort  input  1  host abort; level, sampled each edge
core_done  input  1  halt indication from core
core_rst  output  1  synchronous active-high reset to core
core_en  output  1  core advance enable (PC/regfile/mem write gating)
busy  output  1  run in progress
done  output  1  run finished (halt or timeout)
timed_out  output  1  run ended by watchdog
cycle_cnt  output  CNT_WIDTH  RUN cycles consumed in the current/last run

Behaviour:
- All outputs are registered, Moore-decoded from the state.
- Internal req_q register is used for edge detection; start = req & ~req_q.
- Reset (reset=0, asynchronous):
  - state=IDLE, req_q=0, cycle_cnt=0.
  - core_rst=1, core_en=0, busy=0, done=0, timed_out=0.
  - Reset asserted mid-run aborts immediately to these values.
- States, with outputs (core_rst/core_en/busy/done/timed_out):
  - IDLE 1/0/0/0/0
  - RSTC 1/0/1/0/0
  - RUN 0/1/1/0/0
  - DONE 0/0/0/1/0
  - FAULT 0/0/0/1/1
- IDLE:
  - start → RSTC; rst counter loaded with RST_CYCLES-1; cycle_cnt cleared to 0.
- RSTC:
  - Stays exactly RST_CYCLES cycles, counting down; at 0 → RUN.
  - abort → IDLE.
  - start is ignored.
- RUN, on each edge, in priority order:
  - abort=1 → IDLE; cycle_cnt holds.
  - Otherwise cycle_cnt increments.
  - core_done=1 → DONE.
  - Else, if TIMEOUT≠0 and the incremented value == TIMEOUT → FAULT.
  - Else stay in RUN.
  - Therefore cycle_cnt = number of RUN cycles including the cycle in which core_done was high.
  - core_done and the timeout in the same cycle resolve to DONE.
  - cycle_cnt saturates at all-ones (reachable only with TIMEOUT=0).
  - start is ignored.
- DONE / FAULT:
  - Hold; cycle_cnt is frozen for readout.
  - start → RSTC (restart, cycle_cnt cleared, done/timed_out drop on entry).
  - abort → IDLE; abort has priority over start.
- Latency:
  - Start edge sampled at edge k → core_rst released after edge k+RST_CYCLES.
  - First core_en=1 cycle follows that edge.
  - core_done sampled at edge n → done=1 and core_en=0 after edge n; no extra core instruction is enabled.
- req held high does not retrigger; req must go low for ≥1 cycle before the next start.
- core_done outside RUN is ignored.

Test Plan:
- Basic run, RST_CYCLES=2: reset low 2 cycles then high; pulse req at edge 5; core_done high in the 10th RUN cycle → core_rst high through edge 7, then core_en=1 for 10 cycles; afterwards done=1, busy=0, timed_out=0, cycle_cnt=10.
- Watchdog, TIMEOUT=20, core_done tied 0 → FAULT after 20 RUN cycles: done=1, timed_out=1, cycle_cnt=20, core_en=0.
- Simultaneous: core_done=1 on the 20th cycle with TIMEOUT=20 → DONE, timed_out=0, cycle_cnt=20. Same cycle with abort=1 → IDLE, cycle_cnt=19, done=0.
- Start filtering: req held high 50 cycles across a run → exactly one run. Extra req pulses during RSTC/RUN → no restart, cycle_cnt unaffected. Pulse in DONE → restart: cycle_cnt=0, done=0 next cycle.
- Async reset mid-RUN (cycle_cnt=7): drop reset between edges → outputs immediately core_rst=1, core_en=0, busy=0, cycle_cnt=0, no clock needed.
- TIMEOUT=0, CNT_WIDTH=4, no core_done → cycle_cnt saturates at 15, state stays RUN, busy=1.
